// File: rtl/imem_loader.sv
// Boot-time instruction loader: clears IMEM, streams an image in from address 0,
// then holds the CPU in reset for RESET_HOLD cycles before releasing it.
module imem_loader #(
  parameter int                WIDTH      = 12,
  parameter int                IMEM_DEPTH = 256,
  parameter int                ADDR_WIDTH = $clog2(IMEM_DEPTH),
  parameter logic [WIDTH-1:0]  CLEAR_WORD = 12'h000,
  parameter int                RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [WIDTH-1:0]      imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMEM_DEPTH - 1);
  localparam logic [7:0]            HOLD_LAST = 8'(RESET_HOLD - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [7:0]            hold_cnt;

  assign s_ready = (state == ST_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      addr_cnt   <= '0;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_CLEAR: begin
          imem_we    <= 1'b1;
          imem_waddr <= addr_cnt;
          imem_wdata <= CLEAR_WORD;
          addr_cnt   <= addr_cnt + 1'b1;
          if (addr_cnt == LAST_ADDR) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // s_ready is implied by being in this state, so s_valid alone is a handshake
          if (s_valid) begin
            imem_we    <= 1'b1;
            imem_waddr <= addr_cnt;
            imem_wdata <= s_data;
            addr_cnt   <= addr_cnt + 1'b1;
            word_count <= word_count + 1'b1;
            if (s_last) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else if (addr_cnt == LAST_ADDR) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_RUN, ST_ERROR: begin
          if (reload) begin
            state      <= ST_CLEAR;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            addr_cnt   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
